mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
Shares the single-port processor memory between three requesters: the external program loader (LD), the data-memory path (DM) and instruction fetch (IF). Priority is LD first, then DM and IF in round-robin order. A grant lasts for the whole multi-cycle memory access and ends with a one-cycle acknowledge, so unit_control-driven IF/DM accesses and the loader can coexist on one memory.

Parameters:
AW, 8, address width
DW, 16, data width
LAT, 2, memory access cycles per transfer; legal range 1..15

Ports:
CLK  in  1  clock; all state changes on the rising edge
RESET  in  1  asynchronous, active-low reset
REQ_LD  in  1  loader request; level, held until ACK_LD
WE_LD  in  1  loader write (1) / read (0)
ADDR_LD  in  AW  loader address
WDATA_LD  in  DW  loader write data
ACK_LD  out  1  loader transfer done; one-cycle pulse
REQ_DM  in  1  data request
WE_DM  in  1  data write (1) / read (0)
ADDR_DM  in  AW  data address
WDATA_DM  in  DW  data write data
ACK_DM  out  1  data transfer done; one-cycle pulse
REQ_IF  in  1  fetch request; always a read
ADDR_IF  in  AW  fetch address
ACK_IF  out  1  fetch done; one-cycle pulse
RDATA  out  DW  read data, registered, shared by all requesters
M_EN  out  1  memory enable
M_WE  out  1  memory write enable
M_ADDR  out  AW  memory address
M_WDATA  out  DW  memory write data
M_RDATA  in  DW  memory read data; valid at the end of the last access cycle
GNT  out  2  current owner: 00 none, 01 IF, 10 DM, 11 LD
BUSY  out  1  high in ACCESS and RESP

Behaviour:
- Reset (RESET low): acts immediately, independent of CLK.
  - All outputs go to 0: ACK_*, M_EN, M_WE, M_ADDR, M_WDATA, RDATA, BUSY, and GNT=00.
  - Internal state: FSM=IDLE, latency counter=0, round-robin pointer RR=0 (0 favours DM).
- FSM states: IDLE, ACCESS, RESP.
- IDLE: arbitration happens only here.
  - REQ_LD wins over everything.
  - Otherwise: if exactly one of REQ_DM/REQ_IF is high, it wins. If both are high, DM wins when RR=0 and IF wins when RR=1.
  - On a winner: latch its address, write data and WE into the M_* output registers. WE is forced to 0 for IF. Set GNT, set counter=LAT-1, go to ACCESS.
  - No request: stay in IDLE with GNT=00.
- ACCESS:
  - M_EN=1 for exactly LAT cycles; M_WE=latched WE for the same cycles.
  - Address and write data stay stable for all of those cycles.
  - Counter decrements each cycle. On the cycle the counter is 0:
    - for a read, capture M_RDATA into RDATA;
    - go to RESP.
- RESP (one cycle):
  - M_EN=0, M_WE=0, and the owner's ACK is high.
  - Update RR: set to 1 after a DM grant, to 0 after an IF grant, unchanged after an LD grant.
  - GNT returns to 00 and the FSM returns to IDLE on the next edge.
- Latency: REQ sampled high in IDLE at cycle 0 → M_EN high in cycles 1..LAT → ACK in cycle LAT+1 → IDLE in cycle LAT+2.
- RDATA holds its value across writes and idle cycles. It changes only on a read capture.
- REQ protocol:
  - REQ is a level. A requester must drop REQ by cycle LAT+2, otherwise it is arbitrated again as a new request.
  - Dropping REQ during ACCESS does not abort the transfer; the ACK is still issued.
- Simultaneous events:
  - ACK_* are mutually exclusive; at most one is high in any cycle.
  - Input changes during ACCESS are ignored, because all operands are latched at grant.
- RESET asserted mid-access: the transfer is abandoned and no ACK is issued. After release the FSM starts in IDLE with RR=0.
- The counter is 4 bits wide. LAT=1 gives a single M_EN cycle and the ACK in cycle 2.

Test Plan:
- Reset: drive RESET low with random inputs → all outputs 0, GNT=00. After release with no REQ, outputs stay 0 for 10 cycles.
- IF read, LAT=2: REQ_IF=1, ADDR_IF=0x10, M_RDATA=0xBEEF → M_EN=1 and M_ADDR=0x10 in cycles 1-2, M_WE=0; ACK_IF=1 in cycle 3; RDATA=0xBEEF.
- DM write: WE_DM=1, ADDR_DM=0x12, WDATA_DM=0x00A5, RDATA previously 0xBEEF → M_WE=1 with M_WDATA=0x00A5 for 2 cycles; ACK_DM=1 in cycle 3; RDATA stays 0xBEEF.
- Contention: REQ_DM and REQ_IF held high continuously → grant order is DM, IF, DM, IF. GNT sequence is 10, 01, 10, 01, with ACKs every 4 cycles (LAT=2).
- Three-way contention: REQ_LD, REQ_DM and REQ_IF all high at once, each requester dropping REQ after its ACK → LD served first (GNT=11), then DM, then IF. RR is unaffected by the LD grant.
- Reset mid-access: pull RESET low in the first ACCESS cycle of a DM read → M_EN, GNT and BUSY go to 0 immediately and no ACK_DM appears. After release with REQ_IF high, IF is granted next cycle.

Source files
------------

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: loader first, then DM/IF round-robin.
// Each grant owns the memory for LAT cycles and then pulses an ACK.
module mem_arbiter #(
  parameter int AW  = 8,
  parameter int DW  = 16,
  parameter int LAT = 2
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          REQ_LD,
  input  logic          WE_LD,
  input  logic [AW-1:0] ADDR_LD,
  input  logic [DW-1:0] WDATA_LD,
  output logic          ACK_LD,
  input  logic          REQ_DM,
  input  logic          WE_DM,
  input  logic [AW-1:0] ADDR_DM,
  input  logic [DW-1:0] WDATA_DM,
  output logic          ACK_DM,
  input  logic          REQ_IF,
  input  logic [AW-1:0] ADDR_IF,
  output logic          ACK_IF,
  output logic [DW-1:0] RDATA,
  output logic          M_EN,
  output logic          M_WE,
  output logic [AW-1:0] M_ADDR,
  output logic [DW-1:0] M_WDATA,
  input  logic [DW-1:0] M_RDATA,
  output logic [1:0]    GNT,
  output logic          BUSY
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  localparam logic [1:0] G_NONE = 2'b00;
  localparam logic [1:0] G_IF   = 2'b01;
  localparam logic [1:0] G_DM   = 2'b10;
  localparam logic [1:0] G_LD   = 2'b11;

  localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

  logic [1:0]    state;
  logic [3:0]    cnt;
  logic          rr;
  logic [1:0]    gnt;
  logic          m_en;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] rdata;
  logic          ack_ld;
  logic          ack_dm;
  logic          ack_if;
  logic          busy;

  logic          pick_ld;
  logic          pick_dm;
  logic          pick_if;
  logic [1:0]    win;
  logic          win_we;
  logic [AW-1:0] win_addr;
  logic [DW-1:0] win_wdata;

  // rr=0 favours DM, rr=1 favours IF when both ask
  assign pick_ld = REQ_LD;
  assign pick_dm = ~REQ_LD & REQ_DM & (~REQ_IF | ~rr);
  assign pick_if = ~REQ_LD & REQ_IF & (~REQ_DM | rr);

  always_comb begin
    win       = G_NONE;
    win_we    = 1'b0;
    win_addr  = '0;
    win_wdata = '0;
    unique case (1'b1)
      pick_ld: begin
        win       = G_LD;
        win_we    = WE_LD;
        win_addr  = ADDR_LD;
        win_wdata = WDATA_LD;
      end
      pick_dm: begin
        win       = G_DM;
        win_we    = WE_DM;
        win_addr  = ADDR_DM;
        win_wdata = WDATA_DM;
      end
      pick_if: begin
        win       = G_IF;
        win_addr  = ADDR_IF;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state   <= S_IDLE;
      cnt     <= '0;
      rr      <= 1'b0;
      gnt     <= G_NONE;
      m_en    <= 1'b0;
      m_we    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      rdata   <= '0;
      ack_ld  <= 1'b0;
      ack_dm  <= 1'b0;
      ack_if  <= 1'b0;
      busy    <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (win != G_NONE) begin
            gnt     <= win;
            m_en    <= 1'b1;
            m_we    <= win_we;
            m_addr  <= win_addr;
            m_wdata <= win_wdata;
            cnt     <= CNT_INIT;
            busy    <= 1'b1;
            state   <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (cnt == 4'd0) begin
            if (!m_we) rdata <= M_RDATA;
            m_en   <= 1'b0;
            m_we   <= 1'b0;
            ack_ld <= (gnt == G_LD);
            ack_dm <= (gnt == G_DM);
            ack_if <= (gnt == G_IF);
            state  <= S_RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_RESP: begin
          ack_ld <= 1'b0;
          ack_dm <= 1'b0;
          ack_if <= 1'b0;
          if (gnt == G_DM) rr <= 1'b1;
          if (gnt == G_IF) rr <= 1'b0;
          gnt    <= G_NONE;
          busy   <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign ACK_LD  = ack_ld;
  assign ACK_DM  = ack_dm;
  assign ACK_IF  = ack_if;
  assign RDATA   = rdata;
  assign M_EN    = m_en;
  assign M_WE    = m_we;
  assign M_ADDR  = m_addr;
  assign M_WDATA = m_wdata;
  assign GNT     = gnt;
  assign BUSY    = busy;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with LAT=2.
// Inputs change and outputs are sampled on the falling edge.
module tb_mem_arbiter;

  logic        CLK;
  logic        RESET;
  logic        REQ_LD, WE_LD;
  logic [7:0]  ADDR_LD;
  logic [15:0] WDATA_LD;
  logic        ACK_LD;
  logic        REQ_DM, WE_DM;
  logic [7:0]  ADDR_DM;
  logic [15:0] WDATA_DM;
  logic        ACK_DM;
  logic        REQ_IF;
  logic [7:0]  ADDR_IF;
  logic        ACK_IF;
  logic [15:0] RDATA;
  logic        M_EN, M_WE;
  logic [7:0]  M_ADDR;
  logic [15:0] M_WDATA;
  logic [15:0] M_RDATA;
  logic [1:0]  GNT;
  logic        BUSY;

  int vectors;
  int miscompares;

  mem_arbiter #(.AW(8), .DW(16), .LAT(2)) dut (
    .CLK(CLK), .RESET(RESET),
    .REQ_LD(REQ_LD), .WE_LD(WE_LD), .ADDR_LD(ADDR_LD),
    .WDATA_LD(WDATA_LD), .ACK_LD(ACK_LD),
    .REQ_DM(REQ_DM), .WE_DM(WE_DM), .ADDR_DM(ADDR_DM),
    .WDATA_DM(WDATA_DM), .ACK_DM(ACK_DM),
    .REQ_IF(REQ_IF), .ADDR_IF(ADDR_IF), .ACK_IF(ACK_IF),
    .RDATA(RDATA), .M_EN(M_EN), .M_WE(M_WE),
    .M_ADDR(M_ADDR), .M_WDATA(M_WDATA), .M_RDATA(M_RDATA),
    .GNT(GNT), .BUSY(BUSY)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic rand_inputs();
    REQ_LD   = 1'($urandom);
    WE_LD    = 1'($urandom);
    ADDR_LD  = 8'($urandom);
    WDATA_LD = 16'($urandom);
    REQ_DM   = 1'($urandom);
    WE_DM    = 1'($urandom);
    ADDR_DM  = 8'($urandom);
    WDATA_DM = 16'($urandom);
    REQ_IF   = 1'($urandom);
    ADDR_IF  = 8'($urandom);
    M_RDATA  = 16'($urandom);
  endtask

  task automatic clear_reqs();
    REQ_LD = 1'b0;
    REQ_DM = 1'b0;
    REQ_IF = 1'b0;
    WE_LD  = 1'b0;
    WE_DM  = 1'b0;
  endtask

  logic [1:0] order [3];
  int         n_gnt;
  logic [1:0] prev_gnt;
  int         acks;
  int         dm_acks;

  initial begin
    vectors     = 0;
    miscompares = 0;
    RESET       = 1'b1;
    rand_inputs();

    // reset with random inputs
    #2 RESET = 1'b0;
    #1;
    check("rst_ctl", 32'({ACK_LD, ACK_DM, ACK_IF, M_EN, M_WE, BUSY, GNT}), 0);
    check("rst_addr", 32'(M_ADDR), 0);
    check("rst_data", {M_WDATA, RDATA}, 0);
    tick();
    rand_inputs();
    tick();
    check("rst_hold", 32'({ACK_LD, ACK_DM, ACK_IF, M_EN, M_WE, BUSY, GNT}), 0);
    clear_reqs();
    M_RDATA = 16'hBEEF;
    RESET   = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle", 32'({ACK_LD, ACK_DM, ACK_IF, M_EN, M_WE, BUSY, GNT}), 0);
    end

    // IF read at 0x10, WE_DM high must not leak into IF
    REQ_IF  = 1'b1;
    ADDR_IF = 8'h10;
    WE_DM   = 1'b1;
    tick();
    check("if_c1", 32'({M_EN, M_WE, BUSY, GNT, M_ADDR}), {1'b1, 1'b0, 1'b1, 2'b01, 8'h10});
    REQ_IF  = 1'b0;
    ADDR_IF = 8'h77;
    tick();
    check("if_c2", 32'({M_EN, M_WE, ACK_IF, M_ADDR}), {1'b1, 1'b0, 1'b0, 8'h10});
    tick();
    check("if_c3", 32'({M_EN, ACK_IF, ACK_DM, ACK_LD, BUSY}), 5'b01001);
    check("if_rdata", 32'(RDATA), 32'hBEEF);
    tick();
    check("if_c4", 32'({ACK_IF, BUSY, GNT}), 0);

    // DM write, RDATA must hold
    REQ_DM   = 1'b1;
    WE_DM    = 1'b1;
    ADDR_DM  = 8'h12;
    WDATA_DM = 16'h00A5;
    M_RDATA  = 16'h1111;
    tick();
    check("dm_c1", {M_EN, M_WE, GNT, 4'h0, M_ADDR, M_WDATA},
          {1'b1, 1'b1, 2'b10, 4'h0, 8'h12, 16'h00A5});
    REQ_DM   = 1'b0;
    WDATA_DM = 16'h5A5A;
    tick();
    check("dm_c2", {M_EN, M_WE, 6'h0, M_ADDR, M_WDATA},
          {1'b1, 1'b1, 6'h0, 8'h12, 16'h00A5});
    tick();
    check("dm_c3", 32'({M_EN, M_WE, ACK_DM, ACK_IF}), 4'b0010);
    check("dm_rdata", 32'(RDATA), 32'hBEEF);
    tick();
    check("dm_c4", 32'({ACK_DM, GNT, BUSY}), 0);
    WE_DM = 1'b0;

    // second IF read puts the round-robin pointer back on DM
    REQ_IF  = 1'b1;
    ADDR_IF = 8'h20;
    M_RDATA = 16'h1234;
    tick();
    check("if2_gnt", 32'({GNT, M_ADDR}), {2'b01, 8'h20});
    REQ_IF = 1'b0;
    tick();
    tick();
    check("if2_ack", 32'(ACK_IF), 1);
    check("if2_rdata", 32'(RDATA), 32'h1234);
    tick();

    // DM/IF contention: DM, IF, DM, IF every 4 cycles
    REQ_DM = 1'b1;
    REQ_IF = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      tick();
      if (c % 4 == 1)
        check("rr_gnt", 32'(GNT), ((c / 4) % 2 == 0) ? 2'b10 : 2'b01);
      if (c % 4 == 3)
        check("rr_ack", 32'({ACK_DM, ACK_IF}),
              ((c / 4) % 2 == 0) ? 2'b10 : 2'b01);
      if (ACK_DM && ACK_IF)
        check("ack_excl", 32'({ACK_DM, ACK_IF}), 0);
    end
    clear_reqs();
    tick();
    check("rr_done", 32'({GNT, BUSY}), 0);

    // three-way contention, each drops REQ on its ACK
    REQ_LD   = 1'b1;
    WE_LD    = 1'b1;
    ADDR_LD  = 8'h30;
    WDATA_LD = 16'hCAFE;
    REQ_DM   = 1'b1;
    REQ_IF   = 1'b1;
    n_gnt    = 0;
    acks     = 0;
    prev_gnt = 2'b00;
    for (int c = 0; c < 40 && acks < 3; c++) begin
      tick();
      if (GNT != 2'b00 && prev_gnt == 2'b00 && n_gnt < 3) begin
        order[n_gnt] = GNT;
        n_gnt++;
      end
      prev_gnt = GNT;
      if (ACK_LD) begin REQ_LD = 1'b0; acks++; end
      if (ACK_DM) begin REQ_DM = 1'b0; acks++; end
      if (ACK_IF) begin REQ_IF = 1'b0; acks++; end
    end
    check("three_acks", 32'(acks), 3);
    check("three_n", 32'(n_gnt), 3);
    if (n_gnt == 3)
      check("three_order", 32'({order[0], order[1], order[2]}),
            {2'b11, 2'b10, 2'b01});
    clear_reqs();
    tick();
    tick();

    // reset in the first ACCESS cycle of a DM read
    REQ_DM  = 1'b1;
    ADDR_DM = 8'h40;
    tick();
    check("mid_c1", 32'({M_EN, GNT, BUSY}), {1'b1, 2'b10, 1'b1});
    #2 RESET = 1'b0;
    #1;
    check("mid_rst", 32'({M_EN, GNT, BUSY}), 0);
    REQ_DM  = 1'b0;
    dm_acks = 0;
    tick();
    if (ACK_DM) dm_acks++;
    REQ_IF  = 1'b1;
    ADDR_IF = 8'h50;
    RESET   = 1'b1;
    tick();
    check("mid_if_gnt", 32'({GNT, M_ADDR}), {2'b01, 8'h50});
    REQ_IF = 1'b0;
    acks   = 0;
    for (int c = 0; c < 6; c++) begin
      if (ACK_DM) dm_acks++;
      if (ACK_IF) acks++;
      tick();
    end
    check("mid_no_dm_ack", 32'(dm_acks), 0);
    check("mid_if_ack", 32'(acks), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
